// File: rtl/urp_pcie_rx_transaction_layer.sv
// PCIe RX transaction layer: decodes 3DW-header TLPs, drops bad ones, and
// sorts good requests/completions into two independent valid/ready FIFOs.
module urp_pcie_rx_transaction_layer #(
    parameter int REQ_DEPTH = 4,
    parameter int CPL_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [223:0] tlp_i,
    input  logic         tlp_valid_i,
    output logic         tlp_ready_o,
    output logic         req_valid_o,
    input  logic         req_ready_i,
    output logic [2:0]   req_fmt_o,
    output logic [4:0]   req_type_o,
    output logic [2:0]   req_tc_o,
    output logic [9:0]   req_length_o,
    output logic [15:0]  req_requestID_o,
    output logic [31:0]  req_addr_o,
    output logic [127:0] req_payload_o,
    output logic         cpl_valid_o,
    input  logic         cpl_ready_i,
    output logic [2:0]   cpl_fmt_o,
    output logic [2:0]   cpl_tc_o,
    output logic [9:0]   cpl_length_o,
    output logic [15:0]  cpl_requestID_o,
    output logic [15:0]  cpl_completID_o,
    output logic [127:0] cpl_payload_o,
    output logic         err_pulse_o,
    output logic [7:0]   err_count_o
);
    localparam int RAW = $clog2(REQ_DEPTH);
    localparam int CAW = $clog2(CPL_DEPTH);

    typedef struct packed {
        logic [2:0]   fmt;
        logic [4:0]   typ;
        logic [2:0]   tc;
        logic [9:0]   length;
        logic [15:0]  rid;
        logic [31:0]  addr;
        logic [127:0] payload;
    } req_t;

    typedef struct packed {
        logic [2:0]   fmt;
        logic [2:0]   tc;
        logic [9:0]   length;
        logic [15:0]  rid;
        logic [15:0]  cid;
        logic [127:0] payload;
    } cpl_t;

    // Header decode
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [2:0]  tc;
    logic [9:0]  len;
    logic        len_ok, req_good, cpl_good, accept, req_push, cpl_push, bad;
    logic        unused_rsvd;

    assign fmt         = tlp_i[223:221];
    assign typ         = tlp_i[220:216];
    assign tc          = tlp_i[214:212];
    assign len         = tlp_i[201:192];
    assign unused_rsvd = ^{tlp_i[215], tlp_i[211:202]};
    assign len_ok      = (len != 10'd0) && (len <= 10'd4);

    assign req_good = (typ == 5'b00000) &&
                      ((fmt == 3'b000) || (fmt == 3'b010 && len_ok));
    assign cpl_good = (typ == 5'b01010) &&
                      ((fmt == 3'b000) || (fmt == 3'b010 && len_ok));

    // FIFO state
    logic [RAW:0] req_wr_q, req_wr_d, req_rd_q, req_rd_d;
    logic [CAW:0] cpl_wr_q, cpl_wr_d, cpl_rd_q, cpl_rd_d;
    req_t         req_mem_q [REQ_DEPTH];
    cpl_t         cpl_mem_q [CPL_DEPTH];
    logic         req_full, req_empty, cpl_full, cpl_empty, req_pop, cpl_pop;
    logic         err_pulse_q, err_pulse_d;
    logic [7:0]   err_count_q, err_count_d;
    req_t         req_head, req_new;
    cpl_t         cpl_head, cpl_new;

    assign req_empty = (req_wr_q == req_rd_q);
    assign cpl_empty = (cpl_wr_q == cpl_rd_q);
    assign req_full  = (req_wr_q[RAW] != req_rd_q[RAW]) &&
                       (req_wr_q[RAW-1:0] == req_rd_q[RAW-1:0]);
    assign cpl_full  = (cpl_wr_q[CAW] != cpl_rd_q[CAW]) &&
                       (cpl_wr_q[CAW-1:0] == cpl_rd_q[CAW-1:0]);

    // Ready depends only on FIFO space, never on the incoming TLP
    assign tlp_ready_o = !req_full && !cpl_full;
    assign accept      = tlp_valid_i && tlp_ready_o;
    assign req_push    = accept && req_good;
    assign cpl_push    = accept && cpl_good;
    assign bad         = accept && !req_good && !cpl_good;
    assign req_pop     = !req_empty && req_ready_i;
    assign cpl_pop     = !cpl_empty && cpl_ready_i;

    assign req_new = '{fmt: fmt, typ: typ, tc: tc, length: len,
                       rid: tlp_i[191:176], addr: tlp_i[159:128],
                       payload: tlp_i[127:0]};
    assign cpl_new = '{fmt: fmt, tc: tc, length: len,
                       rid: tlp_i[191:176], cid: tlp_i[175:160],
                       payload: tlp_i[127:0]};

    always_comb begin
        req_wr_d    = req_wr_q + (RAW+1)'(req_push);
        req_rd_d    = req_rd_q + (RAW+1)'(req_pop);
        cpl_wr_d    = cpl_wr_q + (CAW+1)'(cpl_push);
        cpl_rd_d    = cpl_rd_q + (CAW+1)'(cpl_pop);
        err_pulse_d = bad;
        err_count_d = err_count_q;
        if (bad && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_wr_q    <= '0;
            req_rd_q    <= '0;
            cpl_wr_q    <= '0;
            cpl_rd_q    <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            for (int i = 0; i < REQ_DEPTH; i++) req_mem_q[i] <= '0;
            for (int i = 0; i < CPL_DEPTH; i++) cpl_mem_q[i] <= '0;
        end else begin
            req_wr_q    <= req_wr_d;
            req_rd_q    <= req_rd_d;
            cpl_wr_q    <= cpl_wr_d;
            cpl_rd_q    <= cpl_rd_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            if (req_push) req_mem_q[req_wr_q[RAW-1:0]] <= req_new;
            if (cpl_push) cpl_mem_q[cpl_wr_q[CAW-1:0]] <= cpl_new;
        end
    end

    // Outputs read straight from the head entry
    assign req_head        = req_mem_q[req_rd_q[RAW-1:0]];
    assign cpl_head        = cpl_mem_q[cpl_rd_q[CAW-1:0]];
    assign req_valid_o     = !req_empty;
    assign req_fmt_o       = req_head.fmt;
    assign req_type_o      = req_head.typ;
    assign req_tc_o        = req_head.tc;
    assign req_length_o    = req_head.length;
    assign req_requestID_o = req_head.rid;
    assign req_addr_o      = req_head.addr;
    assign req_payload_o   = req_head.payload;
    assign cpl_valid_o     = !cpl_empty;
    assign cpl_fmt_o       = cpl_head.fmt;
    assign cpl_tc_o        = cpl_head.tc;
    assign cpl_length_o    = cpl_head.length;
    assign cpl_requestID_o = cpl_head.rid;
    assign cpl_completID_o = cpl_head.cid;
    assign cpl_payload_o   = cpl_head.payload;
    assign err_pulse_o     = err_pulse_q;
    assign err_count_o     = err_count_q;
endmodule

// File: tb/tb_urp_pcie_rx_transaction_layer.sv
// Directed bench for the RX transaction layer: hand-computed expectations
// checked with immediate assertions.
module tb_urp_pcie_rx_transaction_layer;
    logic         clk, rst;
    logic [223:0] tlp_i;
    logic         tlp_valid_i, tlp_ready_o;
    logic         req_valid_o, req_ready_i;
    logic [2:0]   req_fmt_o, req_tc_o;
    logic [4:0]   req_type_o;
    logic [9:0]   req_length_o;
    logic [15:0]  req_requestID_o;
    logic [31:0]  req_addr_o;
    logic [127:0] req_payload_o;
    logic         cpl_valid_o, cpl_ready_i;
    logic [2:0]   cpl_fmt_o, cpl_tc_o;
    logic [9:0]   cpl_length_o;
    logic [15:0]  cpl_requestID_o, cpl_completID_o;
    logic [127:0] cpl_payload_o;
    logic         err_pulse_o;
    logic [7:0]   err_count_o;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PL = 128'h0123456789ABCDEF0123456789ABCDEF;

    urp_pcie_rx_transaction_layer #(.REQ_DEPTH(4), .CPL_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .tlp_i(tlp_i), .tlp_valid_i(tlp_valid_i),
        .tlp_ready_o(tlp_ready_o), .req_valid_o(req_valid_o),
        .req_ready_i(req_ready_i), .req_fmt_o(req_fmt_o),
        .req_type_o(req_type_o), .req_tc_o(req_tc_o),
        .req_length_o(req_length_o), .req_requestID_o(req_requestID_o),
        .req_addr_o(req_addr_o), .req_payload_o(req_payload_o),
        .cpl_valid_o(cpl_valid_o), .cpl_ready_i(cpl_ready_i),
        .cpl_fmt_o(cpl_fmt_o), .cpl_tc_o(cpl_tc_o),
        .cpl_length_o(cpl_length_o), .cpl_requestID_o(cpl_requestID_o),
        .cpl_completID_o(cpl_completID_o), .cpl_payload_o(cpl_payload_o),
        .err_pulse_o(err_pulse_o), .err_count_o(err_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [223:0] mk(input logic [2:0] f, input logic [4:0] t,
                                        input logic [2:0] tc, input logic [9:0] len,
                                        input logic [15:0] rid, input logic [15:0] cid,
                                        input logic [31:0] addr, input logic [127:0] pl);
        return {f, t, 1'b0, tc, 10'd0, len, rid, cid, addr, pl};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; tlp_i = '0; tlp_valid_i = 1'b0;
        req_ready_i = 1'b0; cpl_ready_i = 1'b0;
        step(); step();
        chk("rst_req_valid", 128'(req_valid_o), 128'd0);
        chk("rst_cpl_valid", 128'(cpl_valid_o), 128'd0);
        chk("rst_err_pulse", 128'(err_pulse_o), 128'd0);
        chk("rst_err_count", 128'(err_count_o), 128'd0);
        chk("rst_tlp_ready", 128'(tlp_ready_o), 128'd1);
        rst = 1'b0;
        step();

        // MWr delivered next cycle with verbatim fields
        req_ready_i = 1'b1;
        tlp_i = mk(3'b010, 5'b00000, 3'd2, 10'd4, 16'h0100, 16'h0000, 32'h1000_0040, PL);
        tlp_valid_i = 1'b1;
        step();
        tlp_valid_i = 1'b0;
        chk("mwr_valid", 128'(req_valid_o), 128'd1);
        chk("mwr_fmt", 128'(req_fmt_o), 128'd2);
        chk("mwr_type", 128'(req_type_o), 128'd0);
        chk("mwr_tc", 128'(req_tc_o), 128'd2);
        chk("mwr_len", 128'(req_length_o), 128'd4);
        chk("mwr_rid", 128'(req_requestID_o), 128'h0100);
        chk("mwr_addr", 128'(req_addr_o), 128'h1000_0040);
        chk("mwr_payload", req_payload_o, PL);
        chk("mwr_cpl_quiet", 128'(cpl_valid_o), 128'd0);
        step();
        chk("mwr_drained", 128'(req_valid_o), 128'd0);
        chk("mwr_err_count", 128'(err_count_o), 128'd0);

        // CplD then MRd: separate channels, completion held
        tlp_i = mk(3'b010, 5'b01010, 3'd1, 10'd2, 16'h0200, 16'hABCD, 32'h0, PL);
        tlp_valid_i = 1'b1;
        step();
        tlp_i = mk(3'b000, 5'b00000, 3'd0, 10'd0, 16'h0300, 16'h0, 32'h2000_0000, 128'd0);
        step();
        tlp_valid_i = 1'b0;
        chk("mix_req_valid", 128'(req_valid_o), 128'd1);
        chk("mix_req_fmt", 128'(req_fmt_o), 128'd0);
        chk("mix_req_len0", 128'(req_length_o), 128'd0);
        chk("mix_req_addr", 128'(req_addr_o), 128'h2000_0000);
        chk("mix_cpl_valid", 128'(cpl_valid_o), 128'd1);
        step();
        chk("mix_req_gone", 128'(req_valid_o), 128'd0);
        chk("mix_cpl_held", 128'(cpl_valid_o), 128'd1);
        chk("mix_cpl_cid", 128'(cpl_completID_o), 128'hABCD);
        chk("mix_cpl_rid", 128'(cpl_requestID_o), 128'h0200);
        chk("mix_cpl_len", 128'(cpl_length_o), 128'd2);
        chk("mix_cpl_fmt", 128'(cpl_fmt_o), 128'd2);
        chk("mix_cpl_tc", 128'(cpl_tc_o), 128'd1);
        chk("mix_cpl_payload", cpl_payload_o, PL);
        cpl_ready_i = 1'b1;
        step();
        cpl_ready_i = 1'b0;
        chk("mix_cpl_gone", 128'(cpl_valid_o), 128'd0);

        // Back-pressure: five MRd into a four-entry request FIFO
        req_ready_i = 1'b0;
        tlp_valid_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tlp_i = mk(3'b000, 5'b00000, 3'd0, 10'(i), 16'h0400, 16'h0, 32'(i), 128'd0);
            chk("bp_ready_before", 128'(tlp_ready_o), 128'd1);
            step();
        end
        chk("bp_full_ready", 128'(tlp_ready_o), 128'd0);
        tlp_i = mk(3'b000, 5'b00000, 3'd0, 10'd5, 16'h0400, 16'h0, 32'd5, 128'd0);
        step();
        chk("bp_held_ready", 128'(tlp_ready_o), 128'd0);
        chk("bp_head_len", 128'(req_length_o), 128'd1);
        req_ready_i = 1'b1;
        step();
        req_ready_i = 1'b0;
        chk("bp_ready_after_pop", 128'(tlp_ready_o), 128'd1);
        step();
        tlp_valid_i = 1'b0;
        chk("bp_full_again", 128'(tlp_ready_o), 128'd0);
        req_ready_i = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("bp_order_valid", 128'(req_valid_o), 128'd1);
            chk("bp_order_len", 128'(req_length_o), 128'(i));
            chk("bp_order_addr", 128'(req_addr_o), 128'(i));
            step();
        end
        chk("bp_empty", 128'(req_valid_o), 128'd0);
        cpl_ready_i = 1'b1;

        // Unsupported type, MWr len 0, MWr len 5
        tlp_valid_i = 1'b1;
        tlp_i = mk(3'b000, 5'b00100, 3'd0, 10'd1, 16'h0, 16'h0, 32'h0, 128'd0);
        step();
        chk("err1_pulse", 128'(err_pulse_o), 128'd1);
        tlp_i = mk(3'b010, 5'b00000, 3'd0, 10'd0, 16'h0, 16'h0, 32'h0, 128'd0);
        step();
        chk("err2_pulse", 128'(err_pulse_o), 128'd1);
        tlp_i = mk(3'b010, 5'b00000, 3'd0, 10'd5, 16'h0, 16'h0, 32'h0, 128'd0);
        step();
        chk("err3_pulse", 128'(err_pulse_o), 128'd1);
        chk("err3_no_req", 128'(req_valid_o), 128'd0);
        chk("err3_no_cpl", 128'(cpl_valid_o), 128'd0);
        tlp_valid_i = 1'b0;
        step();
        chk("err_pulse_off", 128'(err_pulse_o), 128'd0);
        chk("err_count3", 128'(err_count_o), 128'd3);
        chk("err_no_req", 128'(req_valid_o), 128'd0);
        chk("err_no_cpl", 128'(cpl_valid_o), 128'd0);

        // CplD with len 5 is malformed too; flood to saturation
        tlp_i = mk(3'b010, 5'b01010, 3'd0, 10'd5, 16'h0, 16'h0, 32'h0, 128'd0);
        tlp_valid_i = 1'b1;
        for (int i = 0; i < 260; i++) step();
        tlp_valid_i = 1'b0;
        step();
        chk("err_saturate", 128'(err_count_o), 128'd255);
        chk("err_sat_no_cpl", 128'(cpl_valid_o), 128'd0);

        // Two Cpl (length unchecked) queued, then asynchronous reset
        cpl_ready_i = 1'b0;
        tlp_i = mk(3'b000, 5'b01010, 3'd0, 10'd7, 16'h0, 16'h1111, 32'h0, 128'd0);
        tlp_valid_i = 1'b1;
        step();
        tlp_i = mk(3'b000, 5'b01010, 3'd0, 10'd8, 16'h0, 16'h2222, 32'h0, 128'd0);
        step();
        tlp_valid_i = 1'b0;
        chk("pre_rst_cpl_valid", 128'(cpl_valid_o), 128'd1);
        chk("pre_rst_cpl_len", 128'(cpl_length_o), 128'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cpl_valid", 128'(cpl_valid_o), 128'd0);
        chk("arst_err_count", 128'(err_count_o), 128'd0);
        chk("arst_tlp_ready", 128'(tlp_ready_o), 128'd1);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_cpl_valid", 128'(cpl_valid_o), 128'd0);
        tlp_i = mk(3'b000, 5'b01010, 3'd3, 10'd0, 16'h0077, 16'h5555, 32'h0, 128'd0);
        tlp_valid_i = 1'b1;
        step();
        tlp_valid_i = 1'b0;
        chk("new_cpl_valid", 128'(cpl_valid_o), 128'd1);
        chk("new_cpl_cid", 128'(cpl_completID_o), 128'h5555);
        chk("new_cpl_tc", 128'(cpl_tc_o), 128'd3);
        cpl_ready_i = 1'b1;
        step();
        chk("no_stale_cpl", 128'(cpl_valid_o), 128'd0);
        chk("no_stale_req", 128'(req_valid_o), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
